min_max_requester: RTL and testbench
====================================

# min_max_requester

Initiator side of the min/max finder start/Done/ack handshake. It accepts operand triples on a valid/ready request port and drives `xin`/`yin`/`zin` and `start` into a finder. It waits for `Done`, captures `max`/`min` and the latency, pulses `ack`, then presents the result on a valid/ready result port. It sits between a host or sequencer and either finder variant (Moore or Mealy) and replaces hand-written stimulus tasks.

## Interface
- `W`, 3, operand and result width.
- `TIMEOUT`, 64, maximum WAIT cycles before the request is abandoned; range 1..255.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1, `req_ready` out 1: request handshake; a request transfers when both are high at a posedge.
- `req_x`, `req_y`, `req_z` in W: operands.
- `xin`, `yin`, `zin` out W: operands driven to the finder.
- `start` out 1: start pulse to the finder.
- `ack` out 1: acknowledge pulse to the finder.
- `done` in 1: finder `Done`.
- `max_in`, `min_in` in W: finder results.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_max`, `res_min` out W: captured results.
- `res_cycles` out 8: WAIT-state latency, saturating.
- `res_err` out 1: timeout flag.
- `res_mismatch` out 1: self-check flag (see Configuration).
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, WAIT, ACK, RELEASE, RESULT.
- IDLE
  - `req_ready`=1.
  - On transfer: latch `req_x`/`req_y`/`req_z` into `xin`/`yin`/`zin`, then go to START.
- START
  - `start`=1 for exactly one cycle.
  - Clear the cycle counter.
  - Go to WAIT.
- WAIT
  - Increment the counter every cycle, saturating at 255.
  - When `done`=1 is sampled: capture `max_in`/`min_in`, set `res_cycles` to the counter value including the current cycle, then go to ACK.
  - When the counter reaches `TIMEOUT` with `done`=0: set `res_err`=1, set `res_max`=`res_min`=0, and go directly to RESULT with no `ack`.
- ACK
  - `ack`=1 for exactly one cycle.
  - Go to RELEASE.
- RELEASE
  - Stay until `done`=0 is sampled, then go to RESULT.
  - This guarantees no new `start` is issued while the finder still shows `Done`.
- RESULT
  - `res_valid`=1; all `res_*` outputs are held stable until `res_ready`=1 is sampled.
  - On that edge, return to IDLE and clear `res_err`/`res_mismatch`.
- `xin`/`yin`/`zin` stay stable from START until the next request is accepted.
- `start` and `ack` are never high in the same cycle.
- `req_ready` is 0 in every state except IDLE.

## Timing
- Reset values: all outputs are 0, and the state is IDLE. `req_ready` rises in the first cycle after `reset` deasserts.
- Reset asserted mid-operation (any state): at the next posedge the block is in IDLE with `start`=`ack`=`res_valid`=0. The finder is not acked.
- Request accepted at edge 0:
  - `start` is high in cycle 1.
  - WAIT begins at cycle 2.
  - If `done` is first sampled at edge 2+N, then `res_cycles`=N+1, `ack` is high in the following cycle, and `res_valid` comes no earlier than 2 cycles after `ack`.
- Minimum request-to-request period: 6 cycles.
- `done` already high in the START cycle is ignored; only `done` sampled in WAIT counts.
- `res_cycles` saturates at 255 and never wraps.

## Configuration
- `MIN_MAX_REQUESTER_SELF_CHECK_EN`
  - Defined: compute max/min of the latched operands locally and compare them with `max_in`/`min_in` at capture. Any difference sets `res_mismatch`=1 for that result.
  - Undefined: no comparator is present and `res_mismatch` is tied to 0.
  - The timeout path never sets `res_mismatch`.

## Structure
- Package `min_max_pkg` holds the state enum `req_state_t`, the default `W`, and `CYCLE_W`=8.
- Sub-module `min_max_ref3`: combinational max/min of three W-bit operands, instantiated only under the macro.

## Test plan
- (1,2,3), finder raises `done` after 4 WAIT cycles -> `start` high one cycle, `ack` high one cycle, result max=3, min=1, `res_cycles`=4, `res_err`=0.
- `done` held at 0 with `TIMEOUT`=16 -> `res_err`=1 after 16 WAIT cycles, `ack` never asserted, `res_max`=`res_min`=0.
- `res_ready` held low for 10 cycles in RESULT -> `res_valid` and all `res_*` outputs stable, `req_ready`=0 throughout.
- All six permutations of (1,2,3) back-to-back, finder holding `done` for 3 cycles after `ack` -> each `start` occurs only after `done` has dropped, and every result is max=3, min=1.
- `reset` pulsed during WAIT -> next cycle `start`=`ack`=`res_valid`=0 and `busy`=0; a new request then completes normally.
- Macro defined, finder model returns max=2 for (1,2,3) -> `res_mismatch`=1. Macro undefined -> `res_mismatch`=0.

Source files
------------

// File: rtl/min_max_pkg.sv
// Shared types and widths for the min/max finder requester.
package min_max_pkg;

    localparam int unsigned W_DEFAULT = 3;
    localparam int unsigned CYCLE_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_RELEASE,
        S_RESULT
    } req_state_t;

endpackage

// File: rtl/min_max_ref3.sv
// Combinational max/min of three operands; local reference for the result self-check.
module min_max_ref3 #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_max_c,
    output logic [W-1:0] o_min_c
);

    always_comb begin
        o_max_c = i_a;
        o_min_c = i_a;
        if (i_b > o_max_c) o_max_c = i_b;
        if (i_c > o_max_c) o_max_c = i_c;
        if (i_b < o_min_c) o_min_c = i_b;
        if (i_c < o_min_c) o_min_c = i_c;
    end

endmodule

// File: rtl/min_max_requester.sv
// Initiator for the min/max finder start/Done/ack handshake with request and result ports.
// Optional result self-check enabled by MIN_MAX_REQUESTER_SELF_CHECK_EN.
module min_max_requester
    import min_max_pkg::*;
#(
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [W-1:0]       req_x,
    input  logic [W-1:0]       req_y,
    input  logic [W-1:0]       req_z,
    output logic [W-1:0]       xin,
    output logic [W-1:0]       yin,
    output logic [W-1:0]       zin,
    output logic               start,
    output logic               ack,
    input  logic               done,
    input  logic [W-1:0]       max_in,
    input  logic [W-1:0]       min_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_max,
    output logic [W-1:0]       res_min,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic               res_err,
    output logic               res_mismatch,
    output logic               busy
);

    req_state_t         r_state;
    req_state_t         w_state_next;
    logic               r_req_ready;
    logic               r_start;
    logic               r_ack;
    logic               r_res_valid;
    logic               r_busy;
    logic [W-1:0]       r_xin;
    logic [W-1:0]       r_yin;
    logic [W-1:0]       r_zin;
    logic [CYCLE_W-1:0] r_cnt;
    logic [W-1:0]       r_res_max;
    logic [W-1:0]       r_res_min;
    logic [CYCLE_W-1:0] r_res_cycles;
    logic               r_res_err;
    logic               r_res_mismatch;
    logic [CYCLE_W-1:0] w_cnt_inc;
    logic               w_accept;
    logic               w_capture;
    logic               w_timeout;
    logic               w_mismatch;

`ifdef MIN_MAX_REQUESTER_SELF_CHECK_EN
    logic [W-1:0] w_ref_max;
    logic [W-1:0] w_ref_min;

    min_max_ref3 #(.W(W)) u_ref (
        .i_a     (r_xin),
        .i_b     (r_yin),
        .i_c     (r_zin),
        .o_max_c (w_ref_max),
        .o_min_c (w_ref_min)
    );

    assign w_mismatch = (w_ref_max != max_in) || (w_ref_min != min_in);
`else
    assign w_mismatch = 1'b0;
`endif

    // WAIT latency including the current cycle, saturating so it never wraps
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CYCLE_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_req_ready && req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: w_state_next = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    w_capture    = 1'b1;
                    w_state_next = S_ACK;
                end else if (w_cnt_inc == CYCLE_W'(TIMEOUT)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RESULT;
                end
            end
            S_ACK: w_state_next = S_RELEASE;
            // hold off until the finder drops Done so the next start is clean
            S_RELEASE: begin
                if (!done) w_state_next = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b0;
            r_start        <= 1'b0;
            r_ack          <= 1'b0;
            r_res_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_xin          <= '0;
            r_yin          <= '0;
            r_zin          <= '0;
            r_cnt          <= '0;
            r_res_max      <= '0;
            r_res_min      <= '0;
            r_res_cycles   <= '0;
            r_res_err      <= 1'b0;
            r_res_mismatch <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == S_IDLE);
            r_start     <= (w_state_next == S_START);
            r_ack       <= (w_state_next == S_ACK);
            r_res_valid <= (w_state_next == S_RESULT);
            r_busy      <= (w_state_next != S_IDLE);

            if (w_accept) begin
                r_xin <= req_x;
                r_yin <= req_y;
                r_zin <= req_z;
            end

            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_capture) begin
                r_res_max      <= max_in;
                r_res_min      <= min_in;
                r_res_cycles   <= w_cnt_inc;
                r_res_err      <= 1'b0;
                r_res_mismatch <= w_mismatch;
            end else if (w_timeout) begin
                r_res_max      <= '0;
                r_res_min      <= '0;
                r_res_cycles   <= w_cnt_inc;
                r_res_err      <= 1'b1;
                r_res_mismatch <= 1'b0;
            end else if (r_state == S_RESULT && res_ready) begin
                r_res_err      <= 1'b0;
                r_res_mismatch <= 1'b0;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign start        = r_start;
    assign ack          = r_ack;
    assign res_valid    = r_res_valid;
    assign busy         = r_busy;
    assign xin          = r_xin;
    assign yin          = r_yin;
    assign zin          = r_zin;
    assign res_max      = r_res_max;
    assign res_min      = r_res_min;
    assign res_cycles   = r_res_cycles;
    assign res_err      = r_res_err;
    assign res_mismatch = r_res_mismatch;

endmodule

// File: tb/tb_min_max_requester.sv
// Self-checking bench for min_max_requester: bench-side finder model plus directed and random transactions.
module tb_min_max_requester;

    localparam int unsigned W   = 3;
    localparam int unsigned TMO = 16;
`ifdef MIN_MAX_REQUESTER_SELF_CHECK_EN
    localparam bit SELF_CHECK = 1'b1;
`else
    localparam bit SELF_CHECK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_x, req_y, req_z;
    logic [W-1:0] xin, yin, zin;
    logic         start, ack, done;
    logic [W-1:0] max_in, min_in;
    logic         res_valid, res_ready;
    logic [W-1:0] res_max, res_min;
    logic [7:0]   res_cycles;
    logic         res_err, res_mismatch, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    min_max_requester #(.W(W), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_z        (req_z),
        .xin          (xin),
        .yin          (yin),
        .zin          (zin),
        .start        (start),
        .ack          (ack),
        .done         (done),
        .max_in       (max_in),
        .min_in       (min_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_max      (res_max),
        .res_min      (res_min),
        .res_cycles   (res_cycles),
        .res_err      (res_err),
        .res_mismatch (res_mismatch),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    // One request from IDLE to result handshake. n_wait: WAIT cycle (1-based) in which the
    // finder raises Done (outside 1..TMO means never). hold: cycles Done stays high from the
    // ack cycle on. rr: cycles res_ready is held low. corrupt: finder returns a wrong max.
    task automatic run_txn(input int x, input int y, input int z, input int n_wait,
                           input int hold, input int rr, input bit corrupt);
        int          tmax, tmin, fmax, exp_max, exp_min, d;
        bit          tout, exp_mm;
        logic [31:0] ops;
        tmax    = max3(x, y, z);
        tmin    = min3(x, y, z);
        fmax    = corrupt ? (tmax ^ 1) : tmax;
        tout    = (n_wait < 1) || (n_wait > int'(TMO));
        exp_max = tout ? 0 : fmax;
        exp_min = tout ? 0 : tmin;
        exp_mm  = !tout && corrupt && SELF_CHECK;
        ops     = 32'({W'(x), W'(y), W'(z)});

        check_eq("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_x = W'(x); req_y = W'(y); req_z = W'(z);
        step();
        req_valid = 1'b0;
        req_x = W'($urandom); req_y = W'($urandom); req_z = W'($urandom);
        check_eq("start_pulse", 32'(start), 1);
        check_eq("start_ack_excl", 32'(ack), 0);
        check_eq("req_ready_start", 32'(req_ready), 0);
        check_eq("busy_start", 32'(busy), 1);
        check_eq("operands_latched", 32'({xin, yin, zin}), ops);
        // Done seen during START must be ignored
        done   = 1'($urandom_range(0, 1));
        max_in = W'($urandom);
        min_in = W'($urandom);
        step();

        for (int k = 1; k <= int'(TMO); k++) begin
            check_eq("wait_start_low", 32'(start), 0);
            check_eq("wait_ack_low", 32'(ack), 0);
            check_eq("wait_no_valid", 32'(res_valid), 0);
            check_eq("operands_stable", 32'({xin, yin, zin}), ops);
            done   = (k == n_wait);
            max_in = W'(fmax);
            min_in = W'(tmin);
            step();
            if (k == n_wait) break;
        end

        if (!tout) begin
            check_eq("ack_pulse", 32'(ack), 1);
            check_eq("ack_start_excl", 32'(start), 0);
            check_eq("ack_no_valid", 32'(res_valid), 0);
            done = (hold > 0);
            d = (hold + 1 > 2) ? hold + 1 : 2;
            for (int c = 1; c < d; c++) begin
                step();
                check_eq("release_ack_low", 32'(ack), 0);
                check_eq("release_start_low", 32'(start), 0);
                check_eq("release_no_valid", 32'(res_valid), 0);
                done = (c < hold);
            end
            step();
        end
        done = 1'b0;

        for (int r = 0; r <= rr; r++) begin
            check_eq("res_valid", 32'(res_valid), 1);
            check_eq("res_max", 32'(res_max), 32'(exp_max));
            check_eq("res_min", 32'(res_min), 32'(exp_min));
            check_eq("res_err", 32'(res_err), 32'(tout));
            check_eq("res_mismatch", 32'(res_mismatch), 32'(exp_mm));
            if (!tout) check_eq("res_cycles", 32'(res_cycles), 32'(n_wait));
            check_eq("result_req_ready", 32'(req_ready), 0);
            check_eq("result_ack_low", 32'(ack), 0);
            check_eq("result_busy", 32'(busy), 1);
            check_eq("operands_hold", 32'({xin, yin, zin}), ops);
            res_ready = (r == rr);
            step();
        end
        res_ready = 1'b0;

        check_eq("idle_no_valid", 32'(res_valid), 0);
        check_eq("idle_req_ready", 32'(req_ready), 1);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_err_clr", 32'(res_err), 0);
        check_eq("idle_mismatch_clr", 32'(res_mismatch), 0);
    endtask

    int perm [6][3] = '{'{1, 2, 3}, '{1, 3, 2}, '{2, 1, 3}, '{2, 3, 1}, '{3, 1, 2}, '{3, 2, 1}};

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_x     = '0; req_y = '0; req_z = '0;
        done      = 1'b0;
        max_in    = '0; min_in = '0;
        res_ready = 1'b0;
        step();
        step();
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_start", 32'(start), 0);
        check_eq("rst_ack", 32'(ack), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_operands", 32'({xin, yin, zin}), 0);
        check_eq("rst_results", 32'({res_max, res_min, res_cycles, res_err, res_mismatch}), 0);
        reset = 1'b0;
        step();
        check_eq("req_ready_after_rst", 32'(req_ready), 1);

        run_txn(1, 2, 3, 4, 0, 0, 1'b0);
        run_txn(1, 2, 3, 0, 0, 0, 1'b0);
        run_txn(5, 0, 7, 3, 1, 10, 1'b0);
        for (int p = 0; p < 6; p++) run_txn(perm[p][0], perm[p][1], perm[p][2], 2, 3, 0, 1'b0);
        run_txn(4, 6, 2, 1, 0, 0, 1'b0);
        run_txn(4, 6, 2, int'(TMO), 2, 1, 1'b0);
        run_txn(0, 7, 7, int'(TMO) + 1, 0, 2, 1'b0);

        // reset in the middle of WAIT
        req_valid = 1'b1;
        req_x = 3'd6; req_y = 3'd1; req_z = 3'd4;
        step();
        req_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("midrst_start", 32'(start), 0);
        check_eq("midrst_ack", 32'(ack), 0);
        check_eq("midrst_res_valid", 32'(res_valid), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        reset = 1'b0;
        step();
        check_eq("midrst_req_ready", 32'(req_ready), 1);
        run_txn(6, 1, 4, 5, 0, 0, 1'b0);

        run_txn(1, 2, 3, 3, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(1, TMO + 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
